// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator feeding a NoC router injection port.
// Latency: first beat presented the cycle after start is accepted; back-to-back packets without bubbles.
// Backpressure: a beat is held with all fields stable until tready; tvalid never depends on tready combinationally.
module axis_traffic_gen #(
   parameter int TDATA_WIDTH       = 64,
   parameter int TID_WIDTH         = 2,
   parameter int TDEST_WIDTH       = 2,
   parameter int NOC_NUM_ENDPOINTS = 4,
   parameter int LEN_WIDTH         = 8
) (
   input  logic                   clk_usr,
   input  logic                   rst_usr_sync,
   input  logic                   start,
   input  logic [15:0]            num_packets,
   input  logic [LEN_WIDTH-1:0]   pkt_len,
   input  logic [7:0]             gap_cycles,
   input  logic                   dest_rr,
   input  logic [TDEST_WIDTH-1:0] cfg_tdest,
   input  logic [TID_WIDTH-1:0]   cfg_tid,
   output logic                   axis_out_tvalid,
   input  logic                   axis_out_tready,
   output logic [TDATA_WIDTH-1:0] axis_out_tdata,
   output logic                   axis_out_tlast,
   output logic [TID_WIDTH-1:0]   axis_out_tid,
   output logic [TDEST_WIDTH-1:0] axis_out_tdest,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            pkts_sent
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

   state_t                 state_q;
   logic [LEN_WIDTH-1:0]   len_q;      // effective length, never 0
   logic [15:0]            npk_q;
   logic [7:0]             gap_q;
   logic [7:0]             gap_cnt_q;
   logic                   rr_q;
   logic [TID_WIDTH-1:0]   tid_q;
   logic [TDEST_WIDTH-1:0] dest_q;
   logic [15:0]            beat_q;
   logic [15:0]            seq_q;
   logic [15:0]            pkts_q;
   logic                   tvalid_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   xfer;
   logic                   last_beat;
   logic                   last_pkt;
   logic [TDEST_WIDTH-1:0] dest_d;
   logic [15:0]            pkts_d;

   // Decode of registered state: transfer strobe, end of packet, end of run, next destination
   always_comb begin
      xfer      = tvalid_q & axis_out_tready;
      last_beat = (beat_q == (16'(len_q) - 16'd1));
      last_pkt  = (({1'b0, pkts_q} + 17'd1) == {1'b0, npk_q});
      pkts_d    = (pkts_q == 16'hFFFF) ? pkts_q : pkts_q + 16'd1;
      dest_d    = dest_q + 1'b1;
      if (int'(dest_q) + 1 >= NOC_NUM_ENDPOINTS) begin
         dest_d = '0;
      end
   end

   // Run-control FSM with registered stream and status outputs
   always_ff @(posedge clk_usr) begin
      if (rst_usr_sync) begin
         state_q   <= IDLE;
         len_q     <= LEN_WIDTH'(1);
         npk_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         rr_q      <= 1'b0;
         tid_q     <= '0;
         dest_q    <= '0;
         beat_q    <= '0;
         seq_q     <= '0;
         pkts_q    <= '0;
         tvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_q  <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                  npk_q  <= num_packets;
                  gap_q  <= gap_cycles;
                  rr_q   <= dest_rr;
                  tid_q  <= cfg_tid;
                  dest_q <= cfg_tdest;
                  beat_q <= '0;
                  seq_q  <= '0;
                  pkts_q <= '0;
                  if (num_packets == 16'd0) begin
                     state_q <= FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= SEND;
                     tvalid_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (xfer) begin
                  if (last_beat) begin
                     beat_q <= '0;
                     pkts_q <= pkts_d;
                     seq_q  <= seq_q + 16'd1;
                     if (rr_q) begin
                        dest_q <= dest_d;
                     end
                     if (last_pkt) begin
                        state_q  <= FINISH;
                        tvalid_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                     end else if (gap_q != 8'd0) begin
                        state_q   <= GAP;
                        tvalid_q  <= 1'b0;
                        gap_cnt_q <= gap_q - 8'd1;
                     end
                  end else begin
                     beat_q <= beat_q + 16'd1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == 8'd0) begin
                  state_q  <= SEND;
                  tvalid_q <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 8'd1;
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Output field assembly: beat index low, sequence number above, rest zero
   always_comb begin
      axis_out_tdata        = '0;
      axis_out_tdata[15:0]  = beat_q;
      axis_out_tdata[31:16] = seq_q;
   end

   assign axis_out_tvalid = tvalid_q;
   assign axis_out_tlast  = tvalid_q & last_beat;
   assign axis_out_tid    = tid_q;
   assign axis_out_tdest  = dest_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pkts_sent       = pkts_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
module tb_axis_traffic_gen;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [1:0]  tid;
      logic [1:0]  dest;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_packets = '0;
   logic [7:0]  pkt_len = '0;
   logic [7:0]  gap_cycles = '0;
   logic        dest_rr = 1'b0;
   logic [1:0]  cfg_tdest = '0;
   logic [1:0]  cfg_tid = '0;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic        tlast;
   logic [1:0]  tid;
   logic [1:0]  tdest;
   logic        busy;
   logic        done;
   logic [15:0] pkts_sent;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_err = 0;
   int    done_cnt = 0;
   int    idle_cnt = 0;
   int    cur_np = 0;
   bit    rand_ready = 1'b0;

   logic  prev_stall = 1'b0;
   logic  prev_tlast_xfer = 1'b0;
   logic [68:0] prev_fields = '0;

   axis_traffic_gen dut (
      .clk_usr         (clk),
      .rst_usr_sync    (rst),
      .start           (start),
      .num_packets     (num_packets),
      .pkt_len         (pkt_len),
      .gap_cycles      (gap_cycles),
      .dest_rr         (dest_rr),
      .cfg_tdest       (cfg_tdest),
      .cfg_tid         (cfg_tid),
      .axis_out_tvalid (tvalid),
      .axis_out_tready (tready),
      .axis_out_tdata  (tdata),
      .axis_out_tlast  (tlast),
      .axis_out_tid    (tid),
      .axis_out_tdest  (tdest),
      .busy            (busy),
      .done            (done),
      .pkts_sent       (pkts_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // tready: always high, or a coin toss per cycle when stalls are requested
   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready = rand_ready ? ($urandom_range(1, 0) != 0) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each transfer, checks stall stability, done and gap cycles
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            chk("stall_hold", {tvalid, tdata, tlast, tid, tdest}, {1'b1, prev_fields});
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_beat: got tdata=%0h with no beat expected", tdata);
            end else begin
               chk("beat", {tdata, tlast, tid, tdest}, exp_q.pop_front());
            end
         end
         if (busy && !tvalid) idle_cnt++;
         if (done) begin
            done_cnt++;
            chk("done_busy_low", busy, 0);
            if (cur_np > 0) chk("done_after_tlast", prev_tlast_xfer, 1);
         end
         prev_tlast_xfer = tvalid && tready && tlast;
         prev_stall      = tvalid && !tready;
         prev_fields     = {tdata, tlast, tid, tdest};
      end else begin
         prev_stall      = 1'b0;
         prev_tlast_xfer = 1'b0;
      end
   end

   function automatic beat_t mk_beat(int p, int b, bit last, int t, int d);
      beat_t e;
      e.data        = '0;
      e.data[15:0]  = 16'(b);
      e.data[31:16] = 16'(p);
      e.last        = last;
      e.tid         = 2'(t);
      e.dest        = 2'(d);
      return e;
   endfunction

   task automatic pulse_start(int np, int len, int gap, bit rr, int dest, int t);
      @(posedge clk);
      #1;
      num_packets = 16'(np);
      pkt_len     = 8'(len);
      gap_cycles  = 8'(gap);
      dest_rr     = rr;
      cfg_tdest   = 2'(dest);
      cfg_tid     = 2'(t);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      num_packets = 16'd9;
      pkt_len     = 8'd7;
      gap_cycles  = 8'd3;
      dest_rr     = ~rr;
      cfg_tdest   = 2'(dest) ^ 2'b11;
      cfg_tid     = 2'(t) ^ 2'b11;
   endtask

   task automatic run(int np, int len, int gap, bit rr, int dest, int t);
      int elen = (len == 0) ? 1 : len;
      int done0, idle0, tmo;
      cur_np = np;
      for (int p = 0; p < np; p++) begin
         for (int b = 0; b < elen; b++) begin
            exp_q.push_back(mk_beat(p, b, b == elen - 1, t, rr ? (dest + p) % 4 : dest));
         end
      end
      done0 = done_cnt;
      idle0 = idle_cnt;
      pulse_start(np, len, gap, rr, dest, t);
      if (np * elen >= 4) begin
         // a start mid-run must be ignored
         @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      tmo = 0;
      while (done_cnt == done0 && tmo < 3000) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 3000) begin
         n_checks++;
         n_err++;
         $display("FAIL done_timeout: got no done within 3000 cycles, np=%0d", np);
      end
      repeat (3) @(negedge clk);
      chk("done_once", 128'(done_cnt - done0), 1);
      chk("pkts_sent", pkts_sent, np);
      chk("all_beats_seen", 128'(exp_q.size()), 0);
      chk("idle_cycles", 128'(idle_cnt - idle0), (np > 0) ? gap * (np - 1) : 0);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      int tmo;
      int done0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {tvalid, tdata, tlast, tid, tdest, busy, done, pkts_sent},
          {1'b0, 64'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'd0});
      @(posedge clk);
      #1 rst = 1'b0;

      run(3, 4, 0, 1'b0, 1, 2);     // 12 consecutive beats
      run(2, 2, 5, 1'b0, 3, 1);     // 5 idle cycles between packets
      rand_ready = 1'b1;
      run(3, 5, 2, 1'b0, 0, 3);     // random stalls
      run(4, 3, 0, 1'b1, 1, 0);
      rand_ready = 1'b0;
      run(5, 1, 0, 1'b1, 2, 1);     // tdest 2,3,0,1,2
      run(0, 4, 0, 1'b0, 0, 0);     // empty run
      run(3, 0, 1, 1'b0, 2, 2);     // zero length means one beat

      // Reset on beat 2 of a 4-beat packet
      cur_np = 1;
      for (int b = 0; b < 4; b++) exp_q.push_back(mk_beat(0, b, b == 3, 1, 1));
      done0 = done_cnt;
      pulse_start(1, 4, 0, 1'b0, 1, 1);
      tmo = 0;
      while (!(tvalid && tdata[15:0] == 16'd2) && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 200) begin
         n_checks++;
         n_err++;
         $display("FAIL beat2_timeout: got tdata=%0h, beat 2 never presented", tdata);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_tvalid", tvalid, 0);
      chk("abort_busy", busy, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_done", 128'(done_cnt - done0), 0);
      chk("abort_tvalid_stays_low", tvalid, 0);
      chk("abort_pkts_sent", pkts_sent, 0);
      exp_q.delete();
      run(2, 3, 0, 1'b0, 0, 2);     // restarts from sequence 0

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
